// File: rtl/tft_pkg.sv
// Shared timing constants and colour palette for the 480x272 TFT panel,
// used by the timing generator and the screen renderers.
package tft_pkg;

   typedef logic [23:0] rgb_t;

   localparam logic [9:0] TFT_H_SYNC  = 10'd41;
   localparam logic [9:0] TFT_H_BACK  = 10'd2;
   localparam logic [9:0] TFT_H_VALID = 10'd480;
   localparam logic [9:0] TFT_H_FRONT = 10'd2;
   localparam logic [9:0] TFT_V_SYNC  = 10'd10;
   localparam logic [9:0] TFT_V_BACK  = 10'd2;
   localparam logic [9:0] TFT_V_VALID = 10'd272;
   localparam logic [9:0] TFT_V_FRONT = 10'd2;

   localparam logic [9:0] TFT_H_TOTAL     = TFT_H_SYNC + TFT_H_BACK + TFT_H_VALID + TFT_H_FRONT;
   localparam logic [9:0] TFT_V_TOTAL     = TFT_V_SYNC + TFT_V_BACK + TFT_V_VALID + TFT_V_FRONT;
   localparam logic [9:0] TFT_H_ACT_START = TFT_H_SYNC + TFT_H_BACK;
   localparam logic [9:0] TFT_H_ACT_END   = TFT_H_ACT_START + TFT_H_VALID - 10'd1;
   localparam logic [9:0] TFT_V_ACT_START = TFT_V_SYNC + TFT_V_BACK;
   localparam logic [9:0] TFT_V_ACT_END   = TFT_V_ACT_START + TFT_V_VALID - 10'd1;

   localparam rgb_t RED    = 24'hFF0000;
   localparam rgb_t GREEN  = 24'h00FF00;
   localparam rgb_t BLUE   = 24'h0000FF;
   localparam rgb_t PURPLE = 24'hFF00FF;
   localparam rgb_t YELLOW = 24'hFFFF00;
   localparam rgb_t CYAN   = 24'h00FFFF;
   localparam rgb_t ORANGE = 24'hFFA500;
   localparam rgb_t WHITE  = 24'hFFFFFF;
   localparam rgb_t BLACK  = 24'h000000;

   // Bar order of the built-in test pattern, left to right.
   function automatic rgb_t bar_colour(input logic [2:0] idx);
      case (idx)
         3'd0:    return WHITE;
         3'd1:    return YELLOW;
         3'd2:    return CYAN;
         3'd3:    return GREEN;
         3'd4:    return PURPLE;
         3'd5:    return RED;
         3'd6:    return BLUE;
         default: return BLACK;
      endcase
   endfunction

endpackage

// File: rtl/tft_ctrl_if.sv
// Renderer and panel signal bundle of the TFT timing generator.
interface tft_ctrl_if;
   logic [23:0] pix_data;
   logic [9:0]  pix_x;
   logic [9:0]  pix_y;
   logic        hsync;
   logic        vsync;
   logic [23:0] tft_rgb;
   logic        tft_hs;
   logic        tft_vs;
   logic        tft_de;
   logic        tft_clk;
   logic        tft_bl;

   modport master (
      input  pix_data,
      output pix_x, pix_y, hsync, vsync,
      output tft_rgb, tft_hs, tft_vs, tft_de, tft_clk, tft_bl
   );

   modport slave (
      output pix_data,
      input  pix_x, pix_y, hsync, vsync,
      input  tft_rgb, tft_hs, tft_vs, tft_de, tft_clk, tft_bl
   );
endinterface

// File: rtl/tft_test_pattern.sv
// Eight vertical colour bars for panel bring-up; only built when
// TFT_TEST_PATTERN_EN is defined.
module tft_test_pattern
   import tft_pkg::*;
#(
   parameter logic [9:0] BAR_WIDTH = 10'd60
) (
   input  logic [9:0] col,
   output rgb_t       colour
);

   logic [9:0] bar_idx;

   assign bar_idx = col / BAR_WIDTH;
   assign colour  = (bar_idx < 10'd8) ? bar_colour(bar_idx[2:0]) : BLACK;

endmodule

// File: rtl/tft_ctrl.sv
// 480x272 TFT timing generator and pixel output stage. Define
// TFT_TEST_PATTERN_EN to replace renderer data with colour bars.
module tft_ctrl
   import tft_pkg::*;
#(
   parameter logic [9:0] H_SYNC  = TFT_H_SYNC,
   parameter logic [9:0] H_BACK  = TFT_H_BACK,
   parameter logic [9:0] H_VALID = TFT_H_VALID,
   parameter logic [9:0] H_FRONT = TFT_H_FRONT,
   parameter logic [9:0] V_SYNC  = TFT_V_SYNC,
   parameter logic [9:0] V_BACK  = TFT_V_BACK,
   parameter logic [9:0] V_VALID = TFT_V_VALID,
   parameter logic [9:0] V_FRONT = TFT_V_FRONT
) (
   input  logic       tft_clk_9m,
   input  logic       sys_rst_n,
   tft_ctrl_if.master bus
);

   localparam logic [9:0] H_TOTAL     = H_SYNC + H_BACK + H_VALID + H_FRONT;
   localparam logic [9:0] V_TOTAL     = V_SYNC + V_BACK + V_VALID + V_FRONT;
   localparam logic [9:0] H_ACT_START = H_SYNC + H_BACK;
   localparam logic [9:0] H_ACT_END   = H_ACT_START + H_VALID - 10'd1;
   localparam logic [9:0] H_REQ_START = H_ACT_START - 10'd1;
   localparam logic [9:0] H_REQ_END   = H_ACT_END - 10'd1;
   localparam logic [9:0] V_ACT_START = V_SYNC + V_BACK;
   localparam logic [9:0] V_ACT_END   = V_ACT_START + V_VALID - 10'd1;

   logic       run;
   logic [9:0] h_cnt;
   logic [9:0] v_cnt;
   logic       h_act;
   logic       v_act;
   logic       h_req;
   logic       req;
   logic       de;
   rgb_t       rgb_src;

   // run holds outputs idle for the first clock after reset so every frame
   // starts cleanly on the first cycle of the vsync pulse.
   always_ff @(posedge tft_clk_9m or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         run <= 1'b0;
      end else begin
         run <= 1'b1;
      end
   end

   always_ff @(posedge tft_clk_9m or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (run) begin
         if (h_cnt == H_TOTAL - 10'd1) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_TOTAL - 10'd1) ? '0 : v_cnt + 10'd1;
         end else begin
            h_cnt <= h_cnt + 10'd1;
         end
      end
   end

   assign h_act = (h_cnt >= H_ACT_START) && (h_cnt <= H_ACT_END);
   assign v_act = (v_cnt >= V_ACT_START) && (v_cnt <= V_ACT_END);
   // Requests run one clock ahead of DE to cover the renderer's output register.
   assign h_req = (h_cnt >= H_REQ_START) && (h_cnt <= H_REQ_END);
   assign req   = run && v_act && h_req;
   assign de    = run && h_act && v_act;

`ifdef TFT_TEST_PATTERN_EN
   logic [9:0] bar_col;

   assign bar_col = h_cnt - H_ACT_START;

   tft_test_pattern u_test_pattern (
      .col    (bar_col),
      .colour (rgb_src)
   );
`else
   assign rgb_src = bus.pix_data;
`endif

   assign bus.pix_x   = req ? (h_cnt - H_REQ_START) : 10'h3FF;
   assign bus.pix_y   = req ? (v_cnt - V_ACT_START) : 10'h3FF;
   assign bus.tft_hs  = !(run && (h_cnt < H_SYNC));
   assign bus.tft_vs  = !(run && (v_cnt < V_SYNC));
   assign bus.hsync   = bus.tft_hs;
   assign bus.vsync   = bus.tft_vs;
   assign bus.tft_de  = de;
   assign bus.tft_rgb = de ? rgb_src : 24'h0;
   assign bus.tft_clk = tft_clk_9m;
   assign bus.tft_bl  = run;

endmodule
